// File: rtl/int_alu_pipe_pkg.sv
// Shared opcode encoding and helpers for the pipelined integer ALU.
// Imported by the compute stage and by anything that decodes alu_op_e.
package int_alu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_SLL  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_SLT  = 5'd8,
    ALU_SLTU = 5'd9,
    ALU_ADDW = 5'd16,
    ALU_SUBW = 5'd17,
    ALU_SLLW = 5'd21,
    ALU_SRLW = 5'd22,
    ALU_SRAW = 5'd23
  } alu_op_e;

  // Narrower datapaths take the low XLEN bits of this pattern.
  localparam logic [63:0] ALU_ILLEGAL_PATTERN = 64'hDEAD_BEEF_DEAD_BEEF;

  function automatic logic is_word_op(input logic [4:0] opcode);
    case (opcode)
      5'd16, 5'd17, 5'd21, 5'd22, 5'd23: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  // Word ops only exist when there is an upper half to sign-extend into.
  function automatic logic is_legal_op(input logic [4:0] opcode, input int xlen);
    if (opcode <= 5'd9) return 1'b1;
    return is_word_op(opcode) && (xlen == 64);
  endfunction

  function automatic logic [63:0] sext32(input logic [31:0] value);
    return {{32{value[31]}}, value};
  endfunction

endpackage

// File: rtl/int_alu_pipe_if.sv
// Issue-side and writeback-side handshakes of the integer ALU lane.
// master = issue stage / writeback arbiter, slave = the ALU.
interface int_alu_pipe_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_opcode;
  logic [XLEN-1:0]  in_op_a;
  logic [XLEN-1:0]  in_op_b;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport master (
    output in_valid, in_opcode, in_op_a, in_op_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_opcode, in_op_a, in_op_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_err
  );
endinterface

// File: rtl/int_alu_pipe_reg.sv
// One valid/ready register slice carrying the packed {result, tag, err} payload.
// Ready looks only at local valid and downstream ready, never at up_valid.
module alu_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         down_valid,
  input  logic         down_ready,
  output logic [W-1:0] down_data
);

  logic         valid;
  logic [W-1:0] data;

  assign up_ready   = !valid || down_ready;
  assign down_valid = valid;
  assign down_data  = data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (up_ready) begin
        valid <= up_valid;
      end
      // Payload may load during flush; it is harmless because valid is cleared.
      if (up_valid && up_ready) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/int_alu_pipe.sv
// Pipelined RV64I/RV32I integer ALU: compute in front of slice 1, then
// STAGES valid/ready slices in series toward the writeback arbiter.
module int_alu_pipe
  import int_alu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  int_alu_pipe_if.slave  alu
);

  localparam int SHW = $clog2(XLEN);
  localparam int PW  = XLEN + TAG_W + 1;

  alu_op_e         op;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [SHW-1:0]  shamt;
  logic [31:0]     a32;
  logic [31:0]     b32;
  logic [4:0]      shamt32;
  logic [31:0]     w32;
  logic [63:0]     w_sext;
  logic [XLEN-1:0] result;
  logic            err;

  always_comb begin
    op      = alu_op_e'(alu.in_opcode);
    op_a    = alu.in_op_a;
    op_b    = alu.in_op_b;
    shamt   = op_b[SHW-1:0];
    a32     = op_a[31:0];
    b32     = op_b[31:0];
    shamt32 = op_b[4:0];
    w32     = '0;
    w_sext  = '0;
    result  = '0;
    err     = 1'b0;

    if (!is_legal_op(alu.in_opcode, XLEN)) begin
      result = ALU_ILLEGAL_PATTERN[XLEN-1:0];
      err    = 1'b1;
    end else begin
      case (op)
        ALU_ADD:  result = op_a + op_b;
        ALU_SUB:  result = op_a - op_b;
        ALU_AND:  result = op_a & op_b;
        ALU_OR:   result = op_a | op_b;
        ALU_XOR:  result = op_a ^ op_b;
        ALU_SLL:  result = op_a << shamt;
        ALU_SRL:  result = op_a >> shamt;
        ALU_SRA:  result = $unsigned($signed(op_a) >>> shamt);
        ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
        ALU_SLTU: result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
        ALU_ADDW: w32 = a32 + b32;
        ALU_SUBW: w32 = a32 - b32;
        ALU_SLLW: w32 = a32 << shamt32;
        ALU_SRLW: w32 = a32 >> shamt32;
        ALU_SRAW: w32 = $unsigned($signed(a32) >>> shamt32);
        default: begin
          result = ALU_ILLEGAL_PATTERN[XLEN-1:0];
          err    = 1'b1;
        end
      endcase

      if (is_word_op(alu.in_opcode)) begin
        w_sext = sext32(w32);
        result = w_sext[XLEN-1:0];
      end
    end
  end

  // Index 0 is the issue port, index STAGES is the writeback port.
  logic [STAGES:0]         stg_valid;
  logic [STAGES:0]         stg_ready;
  logic [STAGES:0][PW-1:0] stg_data;

  assign stg_valid[0]      = alu.in_valid;
  assign alu.in_ready      = stg_ready[0];
  assign stg_data[0]       = {result, alu.in_tag, err};

  generate
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
      alu_pipe_reg #(
        .W (PW)
      ) u_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .up_valid   (stg_valid[i]),
        .up_ready   (stg_ready[i]),
        .up_data    (stg_data[i]),
        .down_valid (stg_valid[i+1]),
        .down_ready (stg_ready[i+1]),
        .down_data  (stg_data[i+1])
      );
    end
  endgenerate

  assign alu.out_valid     = stg_valid[STAGES];
  assign stg_ready[STAGES] = alu.out_ready;
  assign alu.out_result    = stg_data[STAGES][PW-1 -: XLEN];
  assign alu.out_tag       = stg_data[STAGES][TAG_W:1];
  assign alu.out_err       = stg_data[STAGES][0];

endmodule

// File: tb/tb_int_alu_pipe.sv
// Directed bench: a 64-bit/2-stage ALU and a 32-bit/1-stage ALU side by side,
// vector tables for the op sweep plus sequences for reset, backpressure and flush.
module tb_int_alu_pipe;

  typedef struct {
    logic [4:0]  opcode;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp_res;
    logic        exp_err;
  } vec_t;

  localparam int STAGES64 = 2;
  localparam int STAGES32 = 1;

  logic clk;
  logic rst_n;
  logic flush64;
  logic flush32;

  int n_vec;
  int n_err;

  int_alu_pipe_if #(.XLEN(64), .TAG_W(6)) if64 ();
  int_alu_pipe_if #(.XLEN(32), .TAG_W(6)) if32 ();

  int_alu_pipe #(.XLEN(64), .STAGES(STAGES64), .TAG_W(6)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush64),
    .alu   (if64.slave)
  );

  int_alu_pipe #(.XLEN(32), .STAGES(STAGES32), .TAG_W(6)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush32),
    .alu   (if32.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run64(input vec_t v, input logic [5:0] tag, input string name);
    int lat;
    @(posedge clk); #1;
    if64.in_valid  = 1'b1;
    if64.in_opcode = v.opcode;
    if64.in_op_a   = v.a;
    if64.in_op_b   = v.b;
    if64.in_tag    = tag;
    if64.out_ready = 1'b1;
    @(negedge clk);
    chk({name, "_in_ready"}, 64'(if64.in_ready), 64'd1);
    @(posedge clk); #1;
    if64.in_valid = 1'b0;
    lat = 1;
    while (lat < 10) begin
      @(negedge clk);
      if (if64.out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(STAGES64));
    chk({name, "_result"}, if64.out_result, v.exp_res);
    chk({name, "_tag"}, 64'(if64.out_tag), 64'(tag));
    chk({name, "_err"}, 64'(if64.out_err), 64'(v.exp_err));
    @(posedge clk);
  endtask

  task automatic run32(input vec_t v, input logic [5:0] tag, input string name);
    int lat;
    @(posedge clk); #1;
    if32.in_valid  = 1'b1;
    if32.in_opcode = v.opcode;
    if32.in_op_a   = v.a[31:0];
    if32.in_op_b   = v.b[31:0];
    if32.in_tag    = tag;
    if32.out_ready = 1'b1;
    @(negedge clk);
    chk({name, "_in_ready"}, 64'(if32.in_ready), 64'd1);
    @(posedge clk); #1;
    if32.in_valid = 1'b0;
    lat = 1;
    while (lat < 10) begin
      @(negedge clk);
      if (if32.out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(STAGES32));
    chk({name, "_result"}, 64'(if32.out_result), {32'd0, v.exp_res[31:0]});
    chk({name, "_tag"}, 64'(if32.out_tag), 64'(tag));
    chk({name, "_err"}, 64'(if32.out_err), 64'(v.exp_err));
    @(posedge clk);
  endtask

  vec_t v64[19];
  vec_t v32[7];

  initial begin
    int sent, rcv, occ, cyc;
    logic acc, ret, seen;
    logic [63:0] exp_v;

    n_vec = 0;
    n_err = 0;

    v64[0]  = '{5'd0,  64'd5,                  64'd7,                  64'd12,                 1'b0};
    v64[1]  = '{5'd1,  64'd0,                  64'd1,                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    v64[2]  = '{5'd2,  64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hF000_F000_F000_F000, 1'b0};
    v64[3]  = '{5'd3,  64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hFFF0_FFF0_FFF0_FFF0, 1'b0};
    v64[4]  = '{5'd4,  64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0, 1'b0};
    v64[5]  = '{5'd5,  64'd1,                  64'h43,                 64'd8,                  1'b0};
    v64[6]  = '{5'd6,  64'h8000_0000_0000_0000, 64'd63,                 64'd1,                  1'b0};
    v64[7]  = '{5'd7,  64'h8000_0000_0000_0000, 64'd63,                 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    v64[8]  = '{5'd8,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                  64'd1,                  1'b0};
    v64[9]  = '{5'd9,  64'd1,                  64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                  1'b0};
    v64[10] = '{5'd9,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                  64'd0,                  1'b0};
    v64[11] = '{5'd16, 64'h1234_5678_7FFF_FFFF, 64'd1,                  64'hFFFF_FFFF_8000_0000, 1'b0};
    v64[12] = '{5'd17, 64'h0000_0001_0000_0000, 64'd1,                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    v64[13] = '{5'd21, 64'd1,                  64'd35,                 64'd8,                  1'b0};
    v64[14] = '{5'd22, 64'hFFFF_FFFF_8000_0000, 64'd4,                  64'h0000_0000_0800_0000, 1'b0};
    v64[15] = '{5'd23, 64'hFFFF_FFFF_8000_0000, 64'd4,                  64'hFFFF_FFFF_F800_0000, 1'b0};
    v64[16] = '{5'd10, 64'd3,                  64'd4,                  64'hDEAD_BEEF_DEAD_BEEF, 1'b1};
    v64[17] = '{5'd31, 64'd3,                  64'd4,                  64'hDEAD_BEEF_DEAD_BEEF, 1'b1};
    v64[18] = '{5'd7,  64'h4000_0000_0000_0000, 64'd62,                 64'd1,                  1'b0};

    v32[0] = '{5'd0,  64'hFFFF_FFFF, 64'd1,  64'd0,           1'b0};
    v32[1] = '{5'd16, 64'd1,         64'd1,  64'hDEAD_BEEF,   1'b1};
    v32[2] = '{5'd1,  64'd0,         64'd1,  64'hFFFF_FFFF,   1'b0};
    v32[3] = '{5'd5,  64'd1,         64'd33, 64'd2,           1'b0};
    v32[4] = '{5'd7,  64'h8000_0000, 64'd31, 64'hFFFF_FFFF,   1'b0};
    v32[5] = '{5'd8,  64'h8000_0000, 64'd1,  64'd1,           1'b0};
    v32[6] = '{5'd12, 64'd1,         64'd2,  64'hDEAD_BEEF,   1'b1};

    rst_n   = 1'b0;
    flush64 = 1'b0;
    flush32 = 1'b0;
    if64.in_valid = 1'b0; if64.in_opcode = '0; if64.in_op_a = '0; if64.in_op_b = '0;
    if64.in_tag = '0; if64.out_ready = 1'b1;
    if32.in_valid = 1'b0; if32.in_opcode = '0; if32.in_op_a = '0; if32.in_op_b = '0;
    if32.in_tag = '0; if32.out_ready = 1'b1;

    #3;
    chk("rst_out_valid64", 64'(if64.out_valid), 64'd0);
    chk("rst_out_result64", if64.out_result, 64'd0);
    chk("rst_out_tag64", 64'(if64.out_tag), 64'd0);
    chk("rst_out_err64", 64'(if64.out_err), 64'd0);
    chk("rst_out_valid32", 64'(if32.out_valid), 64'd0);
    #19 rst_n = 1'b1;
    #1;
    chk("rst_in_ready64", 64'(if64.in_ready), 64'd1);
    chk("rst_in_ready32", 64'(if32.in_ready), 64'd1);

    for (int i = 0; i < 19; i++) run64(v64[i], 6'(i), $sformatf("op64_%0d", i));
    for (int i = 0; i < 7; i++)  run32(v32[i], 6'(i + 32), $sformatf("op32_%0d", i));

    // Reset mid-stream: fill the pipe under backpressure, then pull reset.
    @(posedge clk); #1;
    if64.out_ready = 1'b0;
    if64.in_valid  = 1'b1; if64.in_opcode = 5'd0; if64.in_op_a = 64'd1; if64.in_op_b = 64'd1;
    if64.in_tag    = 6'd1;
    @(posedge clk); #1 if64.in_tag = 6'd2;
    @(posedge clk); #1 if64.in_tag = 6'd3;
    @(negedge clk);
    chk("midrst_out_valid_before", 64'(if64.out_valid), 64'd1);
    chk("midrst_in_ready_full", 64'(if64.in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid_during", 64'(if64.out_valid), 64'd0);
    if64.in_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    #1;
    chk("midrst_in_ready_after", 64'(if64.in_ready), 64'd1);
    if64.out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (if64.out_valid) seen = 1'b1;
    end
    chk("midrst_no_stale", 64'(seen), 64'd0);

    // Backpressure: 20 tagged ops, out_ready random.
    sent = 0; rcv = 0; occ = 0; cyc = 0;
    while (rcv < 20 && cyc < 400) begin
      @(posedge clk); #1;
      if64.out_ready = 1'($urandom_range(0, 1));
      if (sent < 20) begin
        if64.in_valid  = 1'b1;
        if64.in_opcode = (sent % 2 == 1) ? 5'd1 : 5'd0;
        if64.in_op_a   = 64'd1000;
        if64.in_op_b   = 64'(sent);
        if64.in_tag    = 6'(sent);
      end else begin
        if64.in_valid = 1'b0;
      end
      @(negedge clk);
      acc = if64.in_valid && if64.in_ready;
      ret = if64.out_valid && if64.out_ready;
      if (!if64.in_ready) chk("bp_stall_only_when_full", 64'(occ), 64'(STAGES64));
      if (ret) begin
        exp_v = (rcv % 2 == 1) ? 64'(1000 - rcv) : 64'(1000 + rcv);
        chk($sformatf("bp_result_%0d", rcv), if64.out_result, exp_v);
        chk($sformatf("bp_tag_%0d", rcv), 64'(if64.out_tag), 64'(rcv));
        rcv++;
      end
      if (acc) sent++;
      occ = occ + int'(acc) - int'(ret);
      cyc++;
    end
    chk("bp_all_received", 64'(rcv), 64'd20);
    @(posedge clk); #1;
    if64.in_valid  = 1'b0;
    if64.out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (if64.out_valid) seen = 1'b1;
    end
    chk("bp_no_duplicate", 64'(seen), 64'd0);

    // Flush: two ops in flight, output retiring and input handshaking in the flush cycle.
    @(posedge clk); #1;
    if64.out_ready = 1'b0;
    if64.in_valid  = 1'b1; if64.in_opcode = 5'd0; if64.in_op_a = 64'd1; if64.in_op_b = 64'd1;
    if64.in_tag    = 6'd40;
    @(posedge clk); #1 if64.in_tag = 6'd41;
    @(posedge clk); #1;
    if64.in_tag    = 6'd42;
    if64.out_ready = 1'b1;
    flush64        = 1'b1;
    @(negedge clk);
    chk("flush_retire_valid", 64'(if64.out_valid), 64'd1);
    chk("flush_retire_tag", 64'(if64.out_tag), 64'd40);
    chk("flush_retire_result", if64.out_result, 64'd2);
    chk("flush_in_ready", 64'(if64.in_ready), 64'd1);
    @(posedge clk); #1;
    flush64       = 1'b0;
    if64.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_empty_next", 64'(if64.out_valid), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (if64.out_valid) seen = 1'b1;
    end
    chk("flush_no_survivor", 64'(seen), 64'd0);
    run64('{5'd0, 64'd10, 64'd20, 64'd30, 1'b0}, 6'd43, "flush_next_op");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
